// File: rtl/ifmap_preload_ctrl.sv
// ifmap_preload_ctrl
//
// Sequencing controller for the ifmap preload FIFO. For each tile it:
//   - gates AXIS beats into the FIFO;
//   - tracks how many complete vectors are resident;
//   - grants FIFO reads to the MAC array only when a fully assembled vector is present.
// Each vector is packed from floor(C/6)+1 AXIS words, six channels per word.
//
// Optional feature: define PRELOAD_CTRL_CHECK_EN to compare the controller's slot
// occupancy against the FIFO's fifo_cnt every cycle. A mismatch sets a sticky chk_err_o.
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   start_i                  tile start pulse, sampled only in IDLE
//   input_channel_size_i     channels per vector (1..MAC_NUM), latched at start
//   vector_num_i             vectors in the tile (non-zero), latched at start
//   s_axis_tvalid_i          AXIS beat valid
//   s_axis_tready_o          AXIS beat accepted
//   load_ifmaps_preload_o    FIFO write strobe (tvalid & tready)
//   fifo_read_o              FIFO read strobe / MAC grant
//   fifo_cnt_i               FIFO occupancy, only observed by the checker
//   mac_req_i                MAC array requests the next vector
//   busy_o                   controller not idle
//   done_o                   one-cycle pulse once the tile has been consumed
//   cfg_err_o                one-cycle pulse after a rejected start
//   chk_err_o                sticky occupancy consistency error
module ifmap_preload_ctrl #(
    parameter int unsigned MAC_NUM    = 256,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned FIFO_CNT_W = 3,
    parameter int unsigned VEC_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [11:0]           input_channel_size_i,
    input  logic [VEC_W-1:0]      vector_num_i,
    input  logic                  s_axis_tvalid_i,
    output logic                  s_axis_tready_o,
    output logic                  load_ifmaps_preload_o,
    output logic                  fifo_read_o,
    input  logic [FIFO_CNT_W-1:0] fifo_cnt_i,
    input  logic                  mac_req_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  cfg_err_o,
    output logic                  chk_err_o
);

    typedef enum logic [1:0] {StIdle, StLoad, StDrain, StDone} state_e;

    state_e           state_q, state_d;
    logic [11:0]      chan_q, chan_d;
    logic [VEC_W-1:0] num_q, num_d;
    logic [8:0]       ch_off_q, ch_off_d;
    logic [VEC_W-1:0] started_q, started_d;
    logic [VEC_W-1:0] wr_done_q, wr_done_d;
    logic [VEC_W-1:0] rd_cnt_q, rd_cnt_d;
    logic             cfg_err_q, cfg_err_d;

    logic             cfg_ok;
    logic             last_word;
    logic [VEC_W-1:0] occupancy;
    logic             active;

    assign cfg_ok = (input_channel_size_i != 12'd0)
                 && (input_channel_size_i <= 12'(MAC_NUM))
                 && (vector_num_i != '0);

    // The word that would carry channels past C closes the vector.
    assign last_word = ({3'b000, ch_off_q} + 12'd6) > chan_q;

    // Slots owned by vectors that have started writing but are not yet read.
    assign occupancy = started_q - rd_cnt_q;
    assign active    = (state_q == StLoad) || (state_q == StDrain);

    // Only fully written vectors are granted; a partial vector is invisible to the MAC.
    assign fifo_read_o = mac_req_i && (wr_done_q != rd_cnt_q) && active;

    // A mid-vector word already has its slot; a new vector needs a free slot, counting
    // the one a same-cycle read releases.
    assign s_axis_tready_o = (state_q == StLoad)
                          && ((ch_off_q != 9'd0) || (occupancy < VEC_W'(FIFO_DEPTH))
                              || fifo_read_o);
    assign load_ifmaps_preload_o = s_axis_tvalid_i && s_axis_tready_o;

    assign busy_o    = (state_q != StIdle);
    assign done_o    = (state_q == StDone);
    assign cfg_err_o = cfg_err_q;

    always_comb begin
        state_d   = state_q;
        chan_d    = chan_q;
        num_d     = num_q;
        ch_off_d  = ch_off_q;
        started_d = started_q;
        wr_done_d = wr_done_q;
        rd_cnt_d  = rd_cnt_q + VEC_W'(fifo_read_o);
        cfg_err_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    if (cfg_ok) begin
                        state_d   = StLoad;
                        chan_d    = input_channel_size_i;
                        num_d     = vector_num_i;
                        ch_off_d  = 9'd0;
                        started_d = '0;
                        wr_done_d = '0;
                        rd_cnt_d  = '0;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            StLoad: begin
                if (load_ifmaps_preload_o) begin
                    if (ch_off_q == 9'd0) begin
                        started_d = started_q + VEC_W'(1);
                    end
                    if (last_word) begin
                        ch_off_d  = 9'd0;
                        wr_done_d = wr_done_q + VEC_W'(1);
                        if (wr_done_q + VEC_W'(1) == num_q) begin
                            state_d = StDrain;
                        end
                    end else begin
                        ch_off_d = ch_off_q + 9'd6;
                    end
                end
            end
            StDrain: begin
                if (fifo_read_o && (rd_cnt_q + VEC_W'(1) == num_q)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            chan_q    <= 12'd0;
            num_q     <= '0;
            ch_off_q  <= 9'd0;
            started_q <= '0;
            wr_done_q <= '0;
            rd_cnt_q  <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            chan_q    <= chan_d;
            num_q     <= num_d;
            ch_off_q  <= ch_off_d;
            started_q <= started_d;
            wr_done_q <= wr_done_d;
            rd_cnt_q  <= rd_cnt_d;
            cfg_err_q <= cfg_err_d;
        end
    end

`ifdef PRELOAD_CTRL_CHECK_EN
    logic chk_err_q, chk_err_d;

    assign chk_err_d = chk_err_q || (occupancy[FIFO_CNT_W-1:0] != fifo_cnt_i);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_err_q <= 1'b0;
        end else begin
            chk_err_q <= chk_err_d;
        end
    end

    assign chk_err_o = chk_err_q;
`else
    logic unused_fifo_cnt;

    assign unused_fifo_cnt = ^fifo_cnt_i;
    assign chk_err_o       = 1'b0;
`endif

endmodule

// File: tb/tb_ifmap_preload_ctrl.sv
// Self-checking bench for ifmap_preload_ctrl. The reference model tracks a tile as
// beats accepted (b) and vectors read (r). Vector state is derived arithmetically
// from those two counts:
//   full    = b / W         vectors completely written
//   started = ceil(b / W)   vectors that own a slot
// where W = C/6 + 1.
module tb_ifmap_preload_ctrl;

    localparam int Depth = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_i;
    logic [11:0] input_channel_size_i;
    logic [15:0] vector_num_i;
    logic        s_axis_tvalid_i;
    logic        s_axis_tready_o;
    logic        load_ifmaps_preload_o;
    logic        fifo_read_o;
    logic [2:0]  fifo_cnt_i;
    logic        mac_req_i;
    logic        busy_o;
    logic        done_o;
    logic        cfg_err_o;
    logic        chk_err_o;

    int n_checks = 0;
    int n_errors = 0;

    ifmap_preload_ctrl #(
        .MAC_NUM    (256),
        .FIFO_DEPTH (4),
        .FIFO_CNT_W (3),
        .VEC_W      (16)
    ) u_dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .start_i               (start_i),
        .input_channel_size_i  (input_channel_size_i),
        .vector_num_i          (vector_num_i),
        .s_axis_tvalid_i       (s_axis_tvalid_i),
        .s_axis_tready_o       (s_axis_tready_o),
        .load_ifmaps_preload_o (load_ifmaps_preload_o),
        .fifo_read_o           (fifo_read_o),
        .fifo_cnt_i            (fifo_cnt_i),
        .mac_req_i             (mac_req_i),
        .busy_o                (busy_o),
        .done_o                (done_o),
        .cfg_err_o             (cfg_err_o),
        .chk_err_o             (chk_err_o)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic bad_start(input int c, input int n);
        @(negedge clk);
        start_i              = 1'b1;
        input_channel_size_i = 12'(c);
        vector_num_i         = 16'(n);
        @(negedge clk);
        start_i = 1'b0;
        #1;
        check_eq("bad_cfg_err", int'(cfg_err_o), 1);
        check_eq("bad_busy", int'(busy_o), 0);
        @(negedge clk);
        #1;
        check_eq("bad_cfg_err_clr", int'(cfg_err_o), 0);
        check_eq("bad_busy_after", int'(busy_o), 0);
    endtask

    // mode 0: random tvalid/mac_req; 1: FIFO-full scenario; 2: partial vector stall;
    // 3: random plus a start pulse during LOAD.
    task automatic run_tile(input int c, input int n, input int mode, input int pv,
                            input int pm, input int exp_first);
        int w, b, r, phase, cyc, nb, nr, first_nb, started, full;
        bit tv, mr, e_read, e_tready, e_load;
        w = c / 6 + 1;
        b = 0; r = 0; nb = 0; nr = 0; first_nb = -1; cyc = 0;
        tv = 1'b0; mr = 1'b0;
        @(negedge clk);
        start_i              = 1'b1;
        input_channel_size_i = 12'(c);
        vector_num_i         = 16'(n);
        s_axis_tvalid_i      = 1'b0;
        mac_req_i            = 1'b0;
        fifo_cnt_i           = 3'd0;
        #1;
        check_eq("pre_busy", int'(busy_o), 0);
        @(negedge clk);
        phase = 1;
        while (phase != 0 && cyc < 6000) begin
            case (mode)
                1: begin
                    tv = 1'b1;
                    mr = (cyc == 12) || (cyc >= 20);
                end
                2: begin
                    tv = (cyc < 3) || (cyc >= 10);
                    mr = 1'b1;
                end
                default: begin
                    tv = ($urandom_range(99) < pv);
                    mr = ($urandom_range(99) < pm);
                end
            endcase
            start_i = (mode == 3) && (cyc == 3);
            if (start_i) input_channel_size_i = 12'd1;
            s_axis_tvalid_i = tv;
            mac_req_i       = mr;
            started    = (b + w - 1) / w;
            full       = b / w;
            fifo_cnt_i = 3'(started - r);
            e_read   = (phase == 1) && mr && (full > r);
            e_tready = (phase == 1) && (b < n * w)
                    && (((b % w) != 0) || (started - r < Depth) || e_read);
            e_load   = e_tready && tv;
            #1;
            if (mode == 1 && cyc == 16) begin
                check_eq("full_beats", nb, 10);
                check_eq("full_reads", nr, 1);
            end
            check_eq("tready", int'(s_axis_tready_o), int'(e_tready));
            check_eq("load", int'(load_ifmaps_preload_o), int'(e_load));
            check_eq("fifo_read", int'(fifo_read_o), int'(e_read));
            check_eq("busy", int'(busy_o), 1);
            check_eq("done", int'(done_o), int'(phase == 2));
            check_eq("cfg_err", int'(cfg_err_o), 0);
            check_eq("chk_err", int'(chk_err_o), 0);
            if (fifo_read_o && first_nb < 0) first_nb = nb;
            if (load_ifmaps_preload_o) nb++;
            if (fifo_read_o) nr++;
            @(posedge clk);
            if (phase == 2) begin
                phase = 0;
            end else begin
                if (e_load) b++;
                if (e_read) begin
                    r++;
                    if (r == n) phase = 2;
                end
            end
            @(negedge clk);
            cyc++;
        end
        start_i         = 1'b0;
        s_axis_tvalid_i = 1'b0;
        mac_req_i       = 1'b0;
        fifo_cnt_i      = 3'd0;
        check_eq("tile_timeout", phase, 0);
        #1;
        check_eq("end_busy", int'(busy_o), 0);
        check_eq("end_done", int'(done_o), 0);
        check_eq("tile_beats", nb, n * w);
        check_eq("tile_reads", nr, n);
        if (exp_first >= 0) check_eq("first_read_beats", first_nb, exp_first);
    endtask

    initial begin
        int exp_chk;
        rst_n                = 1'b0;
        start_i              = 1'b0;
        input_channel_size_i = 12'd0;
        vector_num_i         = 16'd0;
        s_axis_tvalid_i      = 1'b1;
        mac_req_i            = 1'b1;
        fifo_cnt_i           = 3'd0;
        repeat (2) @(negedge clk);
        #1;
        check_eq("rst_tready", int'(s_axis_tready_o), 0);
        check_eq("rst_load", int'(load_ifmaps_preload_o), 0);
        check_eq("rst_read", int'(fifo_read_o), 0);
        check_eq("rst_busy", int'(busy_o), 0);
        check_eq("rst_done", int'(done_o), 0);
        check_eq("rst_cfg_err", int'(cfg_err_o), 0);
        check_eq("rst_chk_err", int'(chk_err_o), 0);
        @(negedge clk);
        s_axis_tvalid_i = 1'b0;
        mac_req_i       = 1'b0;
        rst_n           = 1'b1;

        bad_start(0, 3);
        bad_start(257, 3);
        bad_start(10, 0);

        run_tile(256, 3, 0, 100, 100, 43);
        run_tile(12, 1, 0, 100, 100, 3);
        run_tile(6, 8, 1, 0, 0, -1);
        run_tile(30, 2, 2, 0, 0, 6);
        run_tile(40, 2, 3, 70, 70, -1);
        for (int i = 0; i < 6; i++) begin
            run_tile(int'($urandom_range(256, 1)), int'($urandom_range(5, 1)), 0,
                     int'($urandom_range(100, 30)), int'($urandom_range(100, 30)), -1);
        end

        // Reset in the middle of LOAD.
        @(negedge clk);
        start_i              = 1'b1;
        input_channel_size_i = 12'd60;
        vector_num_i         = 16'd2;
        s_axis_tvalid_i      = 1'b1;
        mac_req_i            = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        #1;
        check_eq("midload_busy", int'(busy_o), 1);
        check_eq("midload_tready", int'(s_axis_tready_o), 1);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_tready", int'(s_axis_tready_o), 0);
        check_eq("midrst_load", int'(load_ifmaps_preload_o), 0);
        check_eq("midrst_read", int'(fifo_read_o), 0);
        check_eq("midrst_busy", int'(busy_o), 0);
        check_eq("midrst_done", int'(done_o), 0);
        check_eq("midrst_chk_err", int'(chk_err_o), 0);
        @(negedge clk);
        rst_n           = 1'b1;
        s_axis_tvalid_i = 1'b0;
        mac_req_i       = 1'b0;
        #1;
        check_eq("postrst_busy", int'(busy_o), 0);

        // Occupancy checker: fifo_cnt off by one while idle.
`ifdef PRELOAD_CTRL_CHECK_EN
        exp_chk = 1;
`else
        exp_chk = 0;
`endif
        @(negedge clk);
        fifo_cnt_i = 3'd1;
        @(negedge clk);
        fifo_cnt_i = 3'd0;
        #1;
        check_eq("chk_set", int'(chk_err_o), exp_chk);
        repeat (3) @(negedge clk);
        #1;
        check_eq("chk_hold", int'(chk_err_o), exp_chk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("chk_clear", int'(chk_err_o), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
